// File: rtl/led_matrix_scan.sv
// Row-multiplexed driver for an 8x8 LED matrix with a double-buffered frame store.
// A producer fills the back buffer and requests a swap; the copy to the front buffer
// happens only at a frame wrap so the display never tears. Each row slot begins with
// a blanking window to suppress ghosting.
// Optional feature: define LED_MATRIX_PWM_EN to add a 3-bit brightness input that
// gates the column drive within the non-blank part of each slot.

module led_matrix_scan #(
  parameter int unsigned ROWS         = 8,
  parameter int unsigned COLS         = 8,
  parameter int unsigned ROW_CYCLES   = 8192,  // must exceed BLANK_CYCLES
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [2:0]      wr_addr,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_req,
`ifdef LED_MATRIX_PWM_EN
  input  logic [2:0]      brightness,
`endif
  output logic            swap_pending,
  output logic            swap_ack,
  output logic            frame_start,
  output logic [COLS-1:0] col,
  output logic [ROWS-1:0] row
);

  localparam int unsigned SlotW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam int unsigned IdxW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [SlotW-1:0] SlotLast = SlotW'(ROW_CYCLES - 1);
  localparam logic [SlotW-1:0] BlankEnd = SlotW'(BLANK_CYCLES);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(ROWS - 1);

  logic [SlotW-1:0] slot_q;
  logic [IdxW-1:0]  idx_q;
  logic [COLS-1:0]  front_q [ROWS];
  logic [COLS-1:0]  back_q  [ROWS];

  logic            slot_wrap;
  logic            frame_wrap;
  logic            blank;
  logic            wr_hit;
  logic [IdxW-1:0] wr_row;
  logic            pwm_on;

  assign slot_wrap  = (slot_q == SlotLast);
  assign frame_wrap = slot_wrap && (idx_q == IdxLast);
  assign blank      = (slot_q < BlankEnd);
  assign wr_hit     = wr_en && (32'(wr_addr) < ROWS);
  assign wr_row     = IdxW'(wr_addr);

`ifdef LED_MATRIX_PWM_EN
  localparam int unsigned Active = ROW_CYCLES - BLANK_CYCLES;

  logic [2:0]  bright_q;
  logic [2:0]  bright_eff;
  logic [31:0] pwm_off;
  logic [31:0] pwm_lhs;
  logic [31:0] pwm_rhs;

  // Brightness latched at slot counter 0; bypass so slot 0 itself sees the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      bright_q <= 3'd7;
    end else if (slot_q == '0) begin
      bright_q <= brightness;
    end
  end

  // On-time test: offset into the active window, scaled by 8, against active*(b+1).
  always_comb begin
    bright_eff = (slot_q == '0) ? brightness : bright_q;
    pwm_off    = 32'(slot_q) - BLANK_CYCLES;
    pwm_lhs    = pwm_off << 3;
    pwm_rhs    = Active * (32'(bright_eff) + 32'd1);
    pwm_on     = (pwm_lhs < pwm_rhs);
  end
`else
  assign pwm_on = 1'b1;
`endif

  // Slot counter and row index; the index advances when the slot counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      idx_q  <= '0;
    end else if (slot_wrap) begin
      slot_q <= '0;
      idx_q  <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end else begin
      slot_q <= slot_q + 1'b1;
    end
  end

  // Frame store and swap handshake; copy happens on the frame-wrap edge only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        front_q[r] <= '0;
        back_q[r]  <= '0;
      end
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (frame_wrap && swap_pending) begin
        // Non-blocking copy takes back_q from before any write on this same edge.
        front_q      <= back_q;
        swap_pending <= 1'b0;
        swap_ack     <= 1'b1;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
      if (wr_hit) begin
        back_q[wr_row] <= wr_data;
      end
    end
  end

  // Registered drive: blank at the start of each slot, else select row and its pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      if (blank) begin
        col <= '0;
        row <= '1;
      end else begin
        col <= pwm_on ? front_q[idx_q] : '0;
        row <= ~(ROWS'(1) << idx_q);
      end
    end
  end

endmodule
